// File: rtl/row_op_sequencer.sv
// Row-at-a-time sequencer for the row subtract unit: fetches A/B rows, feeds the unit,
// writes each result row back and accumulates a sticky overflow flag.
module row_op_sequencer #(
  parameter int unsigned ROWS   = 5,
  parameter int unsigned ROW_W  = 40,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned OP_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        n_rows,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [ROW_W-1:0]  rd_a,
  input  logic [ROW_W-1:0]  rd_b,
  output logic [ROW_W-1:0]  op_a,
  output logic [ROW_W-1:0]  op_b,
  input  logic [ROW_W-1:0]  op_res,
  input  logic              op_ovf,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ROW_W-1:0]  wr_data,
  output logic              busy,
  output logic              done,
  output logic              ovf_flag
);

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StLoad,
    StExec,
    StWrite,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   row_q, row_d;
  logic [ADDR_W-1:0]   rows_q, rows_d;
  logic [2:0]          lat_q, lat_d;
  logic                ovf_q, ovf_d;
  logic [ROW_W-1:0]    op_a_q, op_a_d;
  logic [ROW_W-1:0]    op_b_q, op_b_d;
  logic [ADDR_W-1:0]   rows_clamp;

  always_comb begin
    rows_clamp = (32'(n_rows) > ROWS) ? ADDR_W'(ROWS) : ADDR_W'(n_rows);
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    rows_d  = rows_q;
    lat_d   = lat_q;
    ovf_d   = ovf_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          rows_d  = rows_clamp;
          row_d   = '0;
          ovf_d   = 1'b0;
          state_d = (rows_clamp == '0) ? StDone : StRead;
        end
      end
      StRead: begin
        rd_en   = 1'b1;
        state_d = StLoad;
      end
      StLoad: begin
        op_a_d  = rd_a;
        op_b_d  = rd_b;
        lat_d   = 3'(OP_LAT);
        state_d = StExec;
      end
      StExec: begin
        // Operands stay put while the row unit works through its latency.
        lat_d = lat_q - 3'd1;
        if (lat_q == 3'd1) begin
          state_d = StWrite;
        end
      end
      StWrite: begin
        wr_en = 1'b1;
        ovf_d = ovf_q | op_ovf;
        if (row_q == rows_q - ADDR_W'(1)) begin
          state_d = StDone;
        end else begin
          row_d   = row_q + ADDR_W'(1);
          state_d = StRead;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      row_q   <= '0;
      rows_q  <= '0;
      lat_q   <= '0;
      ovf_q   <= 1'b0;
      op_a_q  <= '0;
      op_b_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      rows_q  <= rows_d;
      lat_q   <= lat_d;
      ovf_q   <= ovf_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
    end
  end

  // Addresses are only driven while their strobe is active.
  assign rd_addr  = rd_en ? row_q : '0;
  assign wr_addr  = wr_en ? row_q : '0;
  assign wr_data  = op_res;
  assign op_a     = op_a_q;
  assign op_b     = op_b_q;
  assign busy     = (state_q != StIdle);
  assign ovf_flag = ovf_q;

endmodule

// File: tb/tb_row_op_sequencer.sv
// Bench for row_op_sequencer: OP_LAT=1 and OP_LAT=3 instances share stimulus and are checked
// every cycle against a schedule model; literal checks pin the headline numbers.
module tb_row_op_sequencer;

  localparam int unsigned ROW_W  = 40;
  localparam int unsigned ADDR_W = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [2:0] n_rows = 3'd0;

  always #5 clk = ~clk;

  logic              rd_en[2];
  logic [ADDR_W-1:0] rd_addr[2];
  logic [ROW_W-1:0]  rd_a[2], rd_b[2], op_a[2], op_b[2], op_res[2], wr_data[2];
  logic              op_ovf[2], wr_en[2], busy[2], done[2], ovf_flag[2];
  logic [ADDR_W-1:0] wr_addr[2];

  row_op_sequencer #(.ROWS(5), .ROW_W(40), .ADDR_W(3), .OP_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .n_rows(n_rows),
    .rd_en(rd_en[0]), .rd_addr(rd_addr[0]), .rd_a(rd_a[0]), .rd_b(rd_b[0]),
    .op_a(op_a[0]), .op_b(op_b[0]), .op_res(op_res[0]), .op_ovf(op_ovf[0]),
    .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]),
    .busy(busy[0]), .done(done[0]), .ovf_flag(ovf_flag[0])
  );

  row_op_sequencer #(.ROWS(5), .ROW_W(40), .ADDR_W(3), .OP_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .start(start), .n_rows(n_rows),
    .rd_en(rd_en[1]), .rd_addr(rd_addr[1]), .rd_a(rd_a[1]), .rd_b(rd_b[1]),
    .op_a(op_a[1]), .op_b(op_b[1]), .op_res(op_res[1]), .op_ovf(op_ovf[1]),
    .wr_en(wr_en[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]),
    .busy(busy[1]), .done(done[1]), .ovf_flag(ovf_flag[1])
  );

  // Lane-wise int8 wrapping subtract; bit 40 is the OR of signed lane overflows.
  function automatic logic [40:0] sub_row(input logic [39:0] a, input logic [39:0] b);
    logic [39:0] r;
    logic        o;
    logic [7:0]  d;
    o = 1'b0;
    r = '0;
    for (int k = 0; k < 5; k++) begin
      d = a[8*k+:8] - b[8*k+:8];
      if (a[8*k+7] != b[8*k+7] && d[7] != a[8*k+7]) o = 1'b1;
      r[8*k+:8] = d;
    end
    return {o, r};
  endfunction

  logic [39:0] mem_a[8], mem_b[8];
  logic [40:0] pipe[2][3];
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Operand banks: one-cycle read latency, junk when not read.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rd_en[i]) begin
        rd_a[i] <= mem_a[rd_addr[i]];
        rd_b[i] <= mem_b[rd_addr[i]];
      end else begin
        rd_a[i] <= 40'hDEADBEEF00;
        rd_b[i] <= 40'h5A5A5A5A5A;
      end
    end
  end

  // Row unit emulation with latency 1 (instance 0) and 3 (instance 1).
  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        pipe[i][0] <= '0;
        pipe[i][1] <= '0;
        pipe[i][2] <= '0;
      end else begin
        pipe[i][0] <= sub_row(op_a[i], op_b[i]);
        pipe[i][1] <= pipe[i][0];
        pipe[i][2] <= pipe[i][1];
      end
    end
  end

  assign op_res[0] = pipe[0][0][39:0];
  assign op_ovf[0] = pipe[0][0][40];
  assign op_res[1] = pipe[1][2][39:0];
  assign op_ovf[1] = pipe[1][2][40];

  int passes = 0;
  int checks = 0;

  task automatic chk(input int idx, input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      $display("FAIL [lat%0d] %s at cycle %0d: got %h, expected %h", (idx == 0) ? 1 : 3, nm,
               cyc, act, exp);
    end else begin
      passes++;
    end
  endtask

  // Model state per instance.
  bit          act[2];
  int          t0[2], nr[2], acc_cyc[2], done_dt[2], wr_cnt[2];
  logic        ovf_e[2], ovf_done[2];
  logic [39:0] opa_e[2], opb_e[2];
  logic [39:0] wlog[2][8];

  initial begin
    for (int i = 0; i < 2; i++) begin
      act[i] = 1'b0; ovf_e[i] = 1'b0; opa_e[i] = '0; opb_e[i] = '0;
      done_dt[i] = -1; wr_cnt[i] = 0; acc_cyc[i] = -1; ovf_done[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        int          p, t, td, r, w;
        logic        e_rd, e_wr;
        logic [40:0] res;
        p = (i == 0) ? 4 : 6;
        // Observations of the DUT, used only by the literal checks.
        if (wr_en[i] && !rst) begin
          wlog[i][wr_addr[i]] = wr_data[i];
          wr_cnt[i]++;
        end
        if (done[i] && !rst) begin
          done_dt[i]  = cyc - acc_cyc[i];
          ovf_done[i] = ovf_flag[i];
        end
        if (rst) begin
          chk(i, "rst_busy", busy[i], 0);
          chk(i, "rst_done", done[i], 0);
          chk(i, "rst_rd_en", rd_en[i], 0);
          chk(i, "rst_wr_en", wr_en[i], 0);
          chk(i, "rst_addrs", {rd_addr[i], wr_addr[i]}, 0);
          chk(i, "rst_ovf_flag", ovf_flag[i], 0);
          chk(i, "rst_op_ab", {op_a[i], op_b[i]}, 0);
          chk(i, "rst_wr_data", wr_data[i], 0);
          act[i] = 1'b0; ovf_e[i] = 1'b0; opa_e[i] = '0; opb_e[i] = '0;
        end else if (act[i]) begin
          t    = cyc - t0[i];
          td   = 1 + nr[i] * p;
          e_rd = (t < td) && ((t - 1) % p == 0);
          e_wr = (t >= p) && (t <= nr[i] * p) && (t % p == 0);
          chk(i, "busy", busy[i], 1);
          chk(i, "done", done[i], t == td);
          chk(i, "rd_en", rd_en[i], e_rd);
          chk(i, "wr_en", wr_en[i], e_wr);
          chk(i, "ovf_flag", ovf_flag[i], ovf_e[i]);
          if (e_rd) chk(i, "rd_addr", rd_addr[i], (t - 1) / p);
          if (e_wr) begin
            w   = t / p - 1;
            res = sub_row(mem_a[w], mem_b[w]);
            chk(i, "wr_addr", wr_addr[i], w);
            chk(i, "wr_data", wr_data[i], res[39:0]);
            ovf_e[i] = ovf_e[i] | res[40];
          end
          if (t >= 3 && nr[i] > 0) begin
            r = (t - 3) / p;
            if (r > nr[i] - 1) r = nr[i] - 1;
            opa_e[i] = mem_a[r];
            opb_e[i] = mem_b[r];
          end
          chk(i, "op_a", op_a[i], opa_e[i]);
          chk(i, "op_b", op_b[i], opb_e[i]);
          if (t == td) act[i] = 1'b0;
        end else begin
          chk(i, "idle_busy", busy[i], 0);
          chk(i, "idle_done", done[i], 0);
          chk(i, "idle_strobes", {rd_en[i], wr_en[i]}, 0);
          chk(i, "idle_ovf_flag", ovf_flag[i], ovf_e[i]);
          chk(i, "idle_op_ab", {op_a[i], op_b[i]}, {opa_e[i], opb_e[i]});
          if (start) begin
            act[i]     = 1'b1;
            t0[i]      = cyc;
            acc_cyc[i] = cyc;
            nr[i]      = (n_rows > 3'd5) ? 5 : int'(n_rows);
            ovf_e[i]   = 1'b0;
            done_dt[i] = -1;
            wr_cnt[i]  = 0;
            for (int k = 0; k < 8; k++) wlog[i][k] = '0;
          end
        end
      end
    end
  end

  task automatic wait_idle();
    int k;
    k = 0;
    while ((act[0] || act[1]) && k < 400) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk(0, "op_timeout", act[0] | act[1], 0);
  endtask

  task automatic run_op(input logic [2:0] n);
    @(posedge clk);
    #1;
    n_rows = n;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();
  endtask

  int c0;

  initial begin
    for (int k = 0; k < 8; k++) begin
      mem_a[k] = 40'h0A0A0A0A0A;
      mem_b[k] = 40'h0102030405;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Five rows, no overflow.
    run_op(3'd5);
    chk(0, "t1_done_cycle", done_dt[0], 21);
    chk(1, "t1_done_cycle", done_dt[1], 31);
    chk(0, "t1_write_count", wr_cnt[0], 5);
    chk(0, "t1_row4_data", wlog[0][4], 40'h0908070605);
    chk(0, "t1_ovf_at_done", ovf_done[0], 0);

    // Overflow on row 2 only.
    mem_a[2] = 40'h8000000000;
    mem_b[2] = 40'h0100000000;
    run_op(3'd5);
    chk(0, "t2_row2_top_byte", wlog[0][2][39:32], 8'h7F);
    chk(0, "t2_ovf_at_done", ovf_done[0], 1);
    chk(1, "t2_ovf_at_done", ovf_done[1], 1);

    // Two rows: flag must have been cleared by the new start.
    run_op(3'd2);
    chk(0, "t3_done_cycle", done_dt[0], 9);
    chk(1, "t3_done_cycle", done_dt[1], 13);
    chk(0, "t3_write_count", wr_cnt[0], 2);
    chk(0, "t3_ovf_at_done", ovf_done[0], 0);

    run_op(3'd0);
    chk(0, "t4_done_cycle", done_dt[0], 1);
    chk(1, "t4_done_cycle", done_dt[1], 1);
    chk(0, "t4_write_count", wr_cnt[0], 0);

    run_op(3'd7);
    chk(0, "t5_write_count", wr_cnt[0], 5);
    chk(0, "t5_done_cycle", done_dt[0], 21);
    chk(0, "t5_row2_data", wlog[0][2], 40'h7F00000000);

    // Stray start pulse in cycle 6.
    @(posedge clk);
    #1;
    n_rows = 3'd5;
    start  = 1'b1;
    c0     = cyc;
    @(posedge clk);
    #1;
    start  = 1'b0;
    n_rows = 3'd2;
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();
    chk(0, "t6_accept_cycle", acc_cyc[0], c0);
    chk(0, "t6_done_cycle", done_dt[0], 21);
    chk(0, "t6_write_count", wr_cnt[0], 5);

    // Reset during EXEC of row 3 (cycle 15 for OP_LAT=1).
    @(posedge clk);
    #1;
    n_rows = 3'd5;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk(0, "t7_busy_now", busy[0], 0);
    chk(0, "t7_ovf_now", ovf_flag[0], 0);
    chk(0, "t7_op_a_now", op_a[0], 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk(0, "t7_no_done", done_dt[0], -1);
    chk(0, "t7_partial_writes", wr_cnt[0], 3);
    run_op(3'd5);
    chk(0, "t7_done_cycle", done_dt[0], 21);
    chk(0, "t7_write_count", wr_cnt[0], 5);
    chk(0, "t7_ovf_at_done", ovf_done[0], 1);

    // Start held high through DONE: re-accepted on the first IDLE cycle.
    @(posedge clk);
    #1;
    n_rows = 3'd5;
    start  = 1'b1;
    c0     = cyc;
    repeat (23) @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();
    chk(0, "t8_reaccept_cycle", acc_cyc[0], c0 + 22);
    chk(1, "t8_single_accept", acc_cyc[1], c0);
    chk(0, "t8_done_cycle", done_dt[0], 21);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/row_op_sequencer.md
# row_op_sequencer

Control stage directly upstream of the 40-bit row subtract unit in the matrix coprocessor. Fetches one row of operand matrix A and matrix B at a time from the two operand banks, presents them to the row unit, captures the result row and its overflow bit after the unit's latency, and writes the result row to the result bank. A sticky overflow flag is accumulated over the whole matrix. A `done` pulse marks the end of the operation.

## Interface
Parameters:
- `ROWS`, 5, maximum rows per matrix.
- `ROW_W`, 40, row width in bits (5 × int8).
- `ADDR_W`, 3, row address width.
- `OP_LAT`, 1, row-unit latency in cycles from operands valid to `op_res`/`op_ovf` valid (1..7).

Ports:
- `clk`  in  1  clock. All state changes on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `start`  in  1  begin operation. Sampled only in IDLE.
- `n_rows`  in  3  row count, sampled with `start`.
- `rd_en`  out  1  operand bank read strobe.
- `rd_addr`  out  ADDR_W  operand row address. The same address is applied to both banks.
- `rd_a`, `rd_b`  in  ROW_W  bank A and bank B read data. Valid one cycle after `rd_en`.
- `op_a`, `op_b`  out  ROW_W  registered operands to the row unit (minuend, subtrahend).
- `op_res`  in  ROW_W  row-unit result.
- `op_ovf`  in  1  row-unit overflow.
- `wr_en`  out  1  result bank write strobe.
- `wr_addr`  out  ADDR_W  result row address.
- `wr_data`  out  ROW_W  equals `op_res`, combinational pass-through. Meaningful only when `wr_en` = 1.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`, inclusive.
- `done`  out  1  one-cycle completion pulse.
- `ovf_flag`  out  1  sticky OR of `op_ovf` over all written rows. Cleared on an accepted `start`.

## Operation
- States: IDLE, READ, LOAD, EXEC, WRITE, DONE.
- IDLE:
  - `start`=1 → latch `rows` = min(`n_rows`, ROWS), clear `row` counter and `ovf_flag`.
  - If `rows`=0 → go to DONE. Otherwise → go to READ.
- READ: `rd_en`=1, `rd_addr`=`row` → LOAD.
- LOAD: `rd_a`/`rd_b` are valid; register them into `op_a`/`op_b` at the end of the cycle. Load the latency counter with OP_LAT → EXEC.
- EXEC: count down OP_LAT cycles. `op_a`/`op_b` are held stable. → WRITE.
- WRITE:
  - `wr_en`=1, `wr_addr`=`row`, `wr_data`=`op_res`; `ovf_flag` |= `op_ovf`.
  - If `row` = `rows`−1 → DONE. Otherwise increment `row` → READ.
- DONE: `done`=1 for exactly one cycle → IDLE.
- `start` in any state other than IDLE is ignored and has no effect on the running operation.
- `n_rows` > ROWS is clamped to ROWS. `n_rows`=0 completes with no reads and no writes.
- `row` counter never wraps: the last written address is `rows`−1.
- `op_a`/`op_b` retain their last value after completion and are not cleared by `start`.
- Reset (any state, any time):
  - FSM returns to IDLE.
  - `rd_en`, `wr_en`, `busy`, `done`, `ovf_flag`, `rd_addr`, `wr_addr`, `op_a`, `op_b` all go to 0.
  - A partial operation is abandoned. No `done` is produced, and already-written rows are not undone.
  - The row unit shares `rst`, so `wr_data` is also 0 during reset.

## Timing
- `start` accepted in cycle 0. Each row takes 3+OP_LAT cycles (READ, LOAD, EXEC×OP_LAT, WRITE).
- Row r (0-based) events:
  - READ in cycle 1 + r·(3+OP_LAT).
  - WRITE in cycle (r+1)·(3+OP_LAT).
- `done` in cycle 1 + rows·(3+OP_LAT). With ROWS=5 and OP_LAT=1: `done` in cycle 21.
- With `rows`=0: `done` in cycle 1.
- `busy`=1 in cycles 1 through the `done` cycle. A new `start` is accepted in the cycle after `done` (IDLE).
- Back-to-back operations: a `start` held high through DONE is accepted on the first IDLE cycle.

## Test plan
- Five-row sub, OP_LAT=1, no overflow.
  - Stimulus: bank A rows = 40'h0A0A0A0A0A, bank B rows = 40'h0102030405.
  - Required: five writes to addresses 0..4 with `wr_data`=40'h0908070605, `ovf_flag`=0, `done` in cycle 21.
- Overflow on a single row.
  - Stimulus: row 2 A = 40'h8000000000, B = 40'h0100000000.
  - Required: row 2 written with top byte 8'h7F, `ovf_flag`=1 at `done`, cleared at the next `start`.
- Short and degenerate counts.
  - `n_rows`=2 → writes only to addresses 0 and 1, `done` in cycle 9.
  - `n_rows`=0 → no `rd_en`/`wr_en`, `done` in cycle 1.
  - `n_rows`=7 → clamped to 5 rows.
- `start` pulsed in cycle 6 during an operation → no effect: same write sequence and `done` cycle as without the pulse.
- Reset mid-operation.
  - Stimulus: `rst` asserted during EXEC of row 3.
  - Required: all outputs 0 immediately, no `done`. A subsequent `start` runs a full 5-row operation correctly with `ovf_flag` starting at 0.
- OP_LAT=3 build: per-row period is 6 cycles, `done` in cycle 31 for 5 rows, `op_a`/`op_b` stable throughout each EXEC.
